// File: rtl/ram1_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram1_word_ctrl
// Description : Word-level access controller and two-port round-robin arbiter
//               for the 64 x 1-bit data RAM. Each granted word request is
//               serialised into WORD_W single-bit RAM accesses, LSB first.
//               The block also owns the RAM's asynchronous clear pin.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               reqN_valid/we/addr/wdata/ready - word request handshake, N=0,1
//               clear_req             - request to zero the whole RAM
//               done0/done1           - one-cycle completion pulse per port
//               clear_done            - one-cycle pulse after RAM clear
//               rdata                 - read result (valid with doneN)
//               busy                  - transfer or clear in progress
//               ram_address/datain/store/dataout/clear - RAM pin interface
// Revision    : 1.0 - initial release
// ============================================================================
module ram1_word_ctrl #(
   parameter int WORD_W  = 8,
   parameter int WADDR_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0_valid,
   input  logic               req0_we,
   input  logic [WADDR_W-1:0] req0_addr,
   input  logic [WORD_W-1:0]  req0_wdata,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic               req1_we,
   input  logic [WADDR_W-1:0] req1_addr,
   input  logic [WORD_W-1:0]  req1_wdata,
   output logic               req1_ready,
   input  logic               clear_req,
   output logic               done0,
   output logic               done1,
   output logic               clear_done,
   output logic [WORD_W-1:0]  rdata,
   output logic               busy,
   output logic [5:0]         ram_address,
   output logic               ram_datain,
   output logic               ram_store,
   input  logic               ram_dataout,
   output logic               ram_clear
);

   localparam int C_BIT_W = $clog2(WORD_W);
   localparam logic [C_BIT_W-1:0] C_LAST_BIT = C_BIT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_CLR  = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_ram_clear;
   logic                 r_done0;
   logic                 r_done1;
   logic                 r_clear_done;
   logic [WORD_W-1:0]    r_rdata;
   logic                 r_last_grant;
   logic [C_BIT_W-1:0]   r_bit;
   logic                 r_port;
   logic                 r_we;
   logic [WADDR_W-1:0]   r_addr;
   logic [WORD_W-1:0]    r_wdata;

   logic                 w_idle_free;
   logic                 w_hs0;
   logic                 w_hs1;
   logic                 w_xfer;

   // Grants are only offered in IDLE with no clear pending. On a tie the
   // port that did not win last time gets the grant.
   assign w_idle_free = (r_state == S_IDLE) && !clear_req;
   assign req0_ready  = w_idle_free && req0_valid && (!req1_valid || r_last_grant);
   assign req1_ready  = w_idle_free && req1_valid && (!req0_valid || !r_last_grant);
   assign w_hs0       = req0_valid && req0_ready;
   assign w_hs1       = req1_valid && req1_ready;

   assign w_xfer      = (r_state == S_XFER);
   assign ram_address = w_xfer ? {r_addr, r_bit} : 6'd0;
   assign ram_store   = w_xfer && r_we;
   assign ram_datain  = w_xfer && r_we && r_wdata[r_bit];
   assign ram_clear   = r_ram_clear;

   assign done0       = r_done0;
   assign done1       = r_done1;
   assign clear_done  = r_clear_done;
   assign rdata       = r_rdata;
   assign busy        = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ram_clear  <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_clear_done <= 1'b0;
         r_rdata      <= '0;
         r_last_grant <= 1'b1;
         r_bit        <= '0;
         r_port       <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         // Completion strobes are single-cycle by default.
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_clear_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (clear_req) begin
                  r_state     <= S_CLR;
                  r_ram_clear <= 1'b1;
               end else if (w_hs0 || w_hs1) begin
                  r_port       <= w_hs1;
                  r_we         <= w_hs1 ? req1_we    : req0_we;
                  r_addr       <= w_hs1 ? req1_addr  : req0_addr;
                  r_wdata      <= w_hs1 ? req1_wdata : req0_wdata;
                  r_last_grant <= w_hs1;
                  r_bit        <= '0;
                  r_state      <= S_XFER;
               end
            end
            S_XFER: begin
               // RAM read is combinational, so the addressed bit is present
               // on ram_dataout during this cycle.
               if (!r_we) begin
                  r_rdata[r_bit] <= ram_dataout;
               end
               r_bit <= r_bit + 1'b1;
               if (r_bit == C_LAST_BIT) begin
                  r_state <= S_IDLE;
                  if (r_port) begin
                     r_done1 <= 1'b1;
                  end else begin
                     r_done0 <= 1'b1;
                  end
               end
            end
            S_CLR: begin
               r_ram_clear  <= 1'b0;
               r_clear_done <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_ram_clear <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram1_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram1_word_ctrl
// Description : Self-checking bench for ram1_word_ctrl with a behavioural
//               64 x 1-bit RAM and a word-level shadow memory feeding a
//               completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram1_word_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_we, req1_valid, req1_we;
   logic [2:0] req0_addr, req1_addr;
   logic [7:0] req0_wdata, req1_wdata;
   logic       req0_ready, req1_ready;
   logic       clear_req;
   logic       done0, done1, clear_done;
   logic [7:0] rdata;
   logic       busy;
   logic [5:0] ram_address;
   logic       ram_datain, ram_store, ram_dataout, ram_clear;

   ram1_word_ctrl #(.WORD_W(8), .WADDR_W(3)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .clear_req(clear_req), .done0(done0), .done1(done1),
      .clear_done(clear_done), .rdata(rdata), .busy(busy),
      .ram_address(ram_address), .ram_datain(ram_datain),
      .ram_store(ram_store), .ram_dataout(ram_dataout), .ram_clear(ram_clear)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, clocked write, async clear.
   logic [63:0] mem = 64'h1;
   always @(posedge clk or posedge ram_clear) begin
      if (ram_clear) mem <= '0;
      else if (ram_store) mem[ram_address] <= ram_datain;
   end
   assign ram_dataout = mem[ram_address];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;   // 0 = port0 done, 1 = port1 done, 2 = clear_done
      bit         we;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         grants[$];
   logic [7:0] model[8];
   logic [7:0] last_rd = 8'h00;
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Completion monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      int   kg;
      if (reset) begin
         last_rd = 8'h00;
      end else if (done0 || done1 || clear_done) begin
         chk("strobe_onehot", $countones({done0, done1, clear_done}), 1);
         kg = done0 ? 0 : (done1 ? 1 : 2);
         if (sb.size() == 0) begin
            chk("unexpected_done", kg, 99);
         end else begin
            e = sb.pop_front();
            chk("done_kind", kg, e.kind);
            chk("done_cycle", cyc, e.due);
            if (e.kind < 2) begin
               if (!e.we) begin
                  chk("rdata", rdata, e.data);
                  last_rd = e.data;
               end else begin
                  chk("rdata_hold", rdata, last_rd);
               end
            end
         end
      end
   end

   task automatic set_port(input int p, input bit v, input bit we,
                           input logic [2:0] a, input logic [7:0] d);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   // Raise a request, wait (bounded) for the grant, record the expectation on
   // the handshake edge and drop valid afterwards. Returns in XFER cycle 1.
   task automatic do_req(input int p, input bit we, input logic [2:0] a,
                         input logic [7:0] d, input bit track);
      exp_t e;
      bit   got = 0;
      @(negedge clk);
      set_port(p, 1'b1, we, a, d);
      for (int i = 0; i < 60 && !got; i++) begin
         #1;
         if ((p == 0) ? req0_ready : req1_ready) begin
            got = 1;
            grants.push_back(p);
            if (track) begin
               e.kind = p; e.we = we; e.data = we ? d : model[a]; e.due = cyc + 9;
               sb.push_back(e);
               if (we) model[a] = d;
            end
            @(posedge clk);
            #1;
         end else begin
            @(negedge clk);
         end
      end
      set_port(p, 1'b0, 1'b0, 3'd0, 8'd0);
      chk("handshake_seen", got, 1);
   endtask

   task automatic do_clear();
      exp_t e;
      bit   got = 0;
      @(negedge clk);
      clear_req = 1'b1;
      for (int i = 0; i < 60 && !got; i++) begin
         #1;
         if (!busy) begin
            got = 1;
            e.kind = 2; e.we = 0; e.data = 0; e.due = cyc + 2;
            sb.push_back(e);
            for (int w = 0; w < 8; w++) model[w] = 8'h00;
            @(posedge clk);
            #1;
            clear_req = 1'b0;
            chk("ram_clear_on", ram_clear, 1);
            @(posedge clk);
            #1;
            chk("ram_clear_off", ram_clear, 0);
         end else begin
            @(negedge clk);
         end
      end
      clear_req = 1'b0;
      chk("clear_seen", got, 1);
   endtask

   // Walks XFER cycles 1..8 checking the bit-serial RAM access pattern.
   task automatic chk_xfer(input logic [2:0] a, input bit we, input logic [7:0] d);
      for (int i = 0; i < 8; i++) begin
         chk("ram_address", ram_address, {a, 3'(i)});
         chk("ram_store", ram_store, we);
         if (we) chk("ram_datain", ram_datain, d[i]);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() > 0; i++) begin
         @(negedge clk);
         #2;
      end
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int w = 0; w < 8; w++) model[w] = 8'h00;
      model[0] = 8'h01;
      reset = 1'b1; clear_req = 1'b0;
      set_port(0, 1'b0, 1'b0, 3'd0, 8'd0);
      set_port(1, 1'b0, 1'b0, 3'd0, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_ram_clear", ram_clear, 0);
      chk("rst_dones", {done0, done1, clear_done}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ram_pins", {ram_address, ram_store, ram_datain}, 0);

      // Power-up read of word 0.
      do_req(0, 1'b0, 3'd0, 8'd0, 1'b1);
      chk_xfer(3'd0, 1'b0, 8'd0);
      drain();

      // Write A5 to word 2, then port 1 reads it back.
      do_req(0, 1'b1, 3'd2, 8'hA5, 1'b1);
      chk_xfer(3'd2, 1'b1, 8'hA5);
      drain();
      do_req(1, 1'b0, 3'd2, 8'd0, 1'b1);
      drain();

      // Clear raised in XFER cycle 2 of a port 1 read waits for the read.
      do_req(1, 1'b0, 3'd2, 8'd0, 1'b1);
      @(posedge clk);
      do_clear();
      drain();

      // Arbitration after reset: both ports keep requesting.
      do_reset();
      model[2] = 8'hA5;
      grants.delete();
      fork
         begin repeat (2) do_req(0, 1'b1, 3'd1, 8'h3C, 1'b1); end
         begin repeat (2) do_req(1, 1'b0, 3'd1, 8'd0, 1'b1); end
      join
      drain();
      chk("grant_count", grants.size(), 4);
      for (int i = 0; i < grants.size() && i < 4; i++) chk("grant_order", grants[i], i % 2);

      // Clear has priority over a simultaneous request.
      do_req(0, 1'b1, 3'd7, 8'hFF, 1'b1);
      drain();
      fork
         do_clear();
         do_req(0, 1'b0, 3'd7, 8'd0, 1'b1);
      join
      drain();

      // Reset in XFER cycle 4 of a write aborts it after four bits.
      do_req(0, 1'b1, 3'd3, 8'hFF, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_store", ram_store, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done0", done0, 0);
      model[3] = 8'h0F;
      do_req(0, 1'b0, 3'd3, 8'd0, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram1_word_ctrl.md
# ram1_word_ctrl

Word-level access controller and two-port arbiter for the 64 x 1-bit data RAM (`ram_1bit_6bit_addr`) in the simplest2 microprocessor. It accepts 8-bit word read and write requests from two requesters (port 0: fetch/loader, port 1: execute/data). Requests are granted round-robin. Each granted word is serialised into eight single-bit RAM accesses, LSB first. The block also sequences the RAM's `clear` pin, so no other block drives the RAM directly.

## Interface
- `WORD_W`, 8: bits per word; must divide 64.
- `WADDR_W`, 3: word address width; equals log2(64/WORD_W).
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req0_valid` / `req1_valid` input 1: request pending on that port.
- `req0_we` / `req1_we` input 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` input WADDR_W: word address.
- `req0_wdata` / `req1_wdata` input WORD_W: write data.
- `req0_ready` / `req1_ready` output 1: combinational grant; handshake completes on an edge where valid and ready are both high.
- `clear_req` input 1: request to zero the whole RAM.
- `done0` / `done1` output 1: one-cycle completion pulse for that port.
- `clear_done` output 1: one-cycle pulse after the RAM clear.
- `rdata` output WORD_W: read result; valid while `done0`/`done1` is high for a read, holds its value otherwise.
- `busy` output 1: high in XFER or CLR.
- `ram_address` output 6, `ram_datain` output 1, `ram_store` output 1: drive the RAM `address`, `datain` and `store` pins.
- `ram_dataout` input 1: from the RAM `dataout` pin.
- `ram_clear` output 1: drives the RAM's asynchronous `clear` pin. Must come straight from a flop, with no decode logic.

## Operation
- States are IDLE, XFER and CLR.
- **IDLE, priority order:**
  - `clear_req` has absolute priority. Both readies stay low. Next state is CLR and `ram_clear` is set to 1.
  - Otherwise, a single valid port gets ready.
  - If both ports are valid, the port not granted last gets ready. `last_grant` resets to 1, so port 0 wins the first tie.
- **Handshake:** on the accepting edge the block latches port id, `we`, `addr` and `wdata`. It also clears bit counter `bit` to 0, updates `last_grant`, and moves to XFER.
- **XFER:**
  - `ram_address` = {addr, bit}.
  - Write: `ram_store`=1 and `ram_datain`=wdata[bit].
  - Read: `ram_store`=0, and the rdata shift register captures `ram_dataout` into bit position `bit` on each edge.
  - `bit` increments every edge.
  - On the edge where `bit`==WORD_W-1, the block returns to IDLE and sets `done<port>` for one cycle.
- **CLR:** lasts exactly one cycle with `ram_clear`=1. On exit, `ram_clear`=0, `clear_done`=1 for one cycle, and the state returns to IDLE.
- Readies are low in XFER and CLR. A requester must hold `valid`, `we`, `addr` and `wdata` stable until its handshake.
- Write-only requests leave `rdata` unchanged.
- **Reset values:** state IDLE, `ram_clear` 0, `done0`/`done1`/`clear_done` 0, `rdata` 0, `last_grant` 1, `bit` 0, `busy` 0.
  - In IDLE, `ram_store` is 0, and `ram_address` and `ram_datain` are 0.
  - Reset does not clear RAM contents.

## Timing
- Handshake edge at cycle 0. XFER runs in cycles 1..WORD_W. `done` is high in cycle WORD_W+1 (cycle 9 at default), and that cycle is IDLE.
- A new handshake may complete in the same cycle `done` is high. Back-to-back throughput is one word per WORD_W+1 cycles.
- **Clear latency:** `clear_req` is accepted at cycle 0, `ram_clear` is high in cycle 1, and `clear_done` is high in cycle 2.
- `clear_req` raised during XFER waits. The current transfer finishes, then CLR has priority over pending requests.
- If `reset` is asserted mid-XFER, the next cycle is IDLE with `ram_store`=0 and no `done` pulse. Bits already written remain in the RAM, and the aborted request is not retried.
- If `reset` is asserted in CLR, `ram_clear` drops on the next edge and no `clear_done` pulse is produced.
- A port's valid dropping before its handshake withdraws the request. Dropping valid after the handshake has no effect.

## Test plan
- **Power-up read:** reset, then port 0 reads word 0 → `done0` in cycle 9 with `rdata`=8'h01 (RAM initial `memory[0]`=1). `ram_address` steps 0..7.
- **Write then read:** port 0 writes 8'hA5 to word 2 → `ram_store` high for 8 cycles at addresses 16..23 with data 1,0,1,0,0,1,0,1. Then port 1 reads word 2 → `done1` with `rdata`=8'hA5.
- **Arbitration:** both ports continuously valid after reset → grants go 0,1,0,1. Each `done` arrives 9 cycles after its grant, and `done` never coincides with both ports.
- **Clear priority:** write 8'hFF to word 7, then raise `clear_req` and `req0_valid` together → `ram_clear` high exactly one cycle and `clear_done` follows. Port 0's read of word 7 is granted afterwards and returns 8'h00.
- **Reset mid-write:** start a write of 8'hFF to word 3 and assert `reset` in XFER cycle 4 → `ram_store` is 0 the next cycle and no `done0`. A later read returns 8'h0F.
- **Clear during XFER:** raise `clear_req` in XFER cycle 2 of a port 1 read → `done1` appears at cycle 9, then CLR, then `clear_done`.
